// File: rtl/led_drv_pkg.sv
// Shared constants for the LED PWM driver: board LED count, PWM resolution and
// default timing for the 50 MHz system clock.
package led_drv_pkg;

  localparam int unsigned LED_WIDTH              = 8;
  localparam int unsigned LED_PWM_BITS           = 8;
  localparam int unsigned LED_PRESCALE_50MHZ     = 50;    // 1 MHz PWM tick
  localparam int unsigned LED_BLINK_FRAMES_50MHZ = 1953;  // ~0.5 s blink half-period

  // Bits needed for a counter running 0..terminal-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/led_frame_timer.sv
// Timing base for the LED driver: prescaler, PWM frame counter and blink
// half-period counter.
module led_frame_timer
  import led_drv_pkg::*;
#(
  parameter int unsigned PWM_BITS     = LED_PWM_BITS,
  parameter int unsigned PRESCALE     = LED_PRESCALE_50MHZ,
  parameter int unsigned BLINK_FRAMES = LED_BLINK_FRAMES_50MHZ
) (
  input  logic                clk,
  input  logic                reset,
  output logic                tick,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_end,
  output logic                blink_phase
);

  localparam int unsigned PS_W = cnt_width(PRESCALE);
  localparam int unsigned BL_W = cnt_width(BLINK_FRAMES);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

  logic [PS_W-1:0] prescale_cnt;
  logic [BL_W-1:0] blink_cnt;

  assign tick      = (prescale_cnt == PS_LAST);
  assign frame_end = tick & (&pwm_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
    end else begin
      if (tick) begin
        prescale_cnt <= '0;
        pwm_cnt      <= pwm_cnt + 1'b1;
      end else begin
        prescale_cnt <= prescale_cnt + 1'b1;
      end

      if (frame_end) begin
        if (blink_cnt == BL_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Drives the board LEDs from the PIO pattern with global PWM brightness and a
// per-LED blink mask; inputs are shadowed and only take effect at frame edges.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int unsigned WIDTH        = LED_WIDTH,
  parameter int unsigned PWM_BITS     = LED_PWM_BITS,
  parameter int unsigned PRESCALE     = LED_PRESCALE_50MHZ,
  parameter int unsigned BLINK_FRAMES = LED_BLINK_FRAMES_50MHZ
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    led_pattern,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [WIDTH-1:0]    blink_mask,
  output logic [WIDTH-1:0]    led_out,
  output logic                frame_start
);

  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                frame_end;
  logic                blink_phase;

  logic [WIDTH-1:0]    shadow_pattern;
  logic [PWM_BITS-1:0] shadow_duty;
  logic [WIDTH-1:0]    shadow_mask;

  logic                pwm_on;
  logic [WIDTH-1:0]    led_next;

  led_frame_timer #(
    .PWM_BITS     (PWM_BITS),
    .PRESCALE     (PRESCALE),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .pwm_cnt     (pwm_cnt),
    .frame_end   (frame_end),
    .blink_phase (blink_phase)
  );

  // All-ones duty is forced on so a full-brightness frame has no dark tick.
  always_comb begin
    pwm_on   = (shadow_duty == '1) || (pwm_cnt < shadow_duty);
    led_next = shadow_pattern & {WIDTH{pwm_on}} & ~(shadow_mask & {WIDTH{blink_phase}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_pattern <= '0;
      shadow_duty    <= '0;
      shadow_mask    <= '0;
      led_out        <= '0;
      frame_start    <= 1'b0;
    end else begin
      led_out     <= led_next;
      frame_start <= frame_end;
      if (tick && frame_end) begin
        shadow_pattern <= led_pattern;
        shadow_duty    <= duty;
        shadow_mask    <= blink_mask;
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: directed frame/duty/blink/reset scenarios plus a
// randomized run, both checked cycle by cycle against a frame-arithmetic model.
module tb_led_pwm_driver;

  localparam int unsigned W   = 8;
  localparam int unsigned PB  = 4;
  localparam int unsigned PS  = 2;
  localparam int unsigned PS1 = 1;
  localparam int unsigned BF  = 2;
  localparam int unsigned F   = PS  * (1 << PB);  // 32 cycles per frame
  localparam int unsigned F1  = PS1 * (1 << PB);  // 16 cycles per frame

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  led_pattern = 8'hFF;
  logic [PB-1:0] duty = 4'hF;
  logic [W-1:0]  blink_mask = 8'h00;
  logic [W-1:0]  led_out;
  logic          frame_start;

  logic [W-1:0]  pat1 = 8'hFF;
  logic [PB-1:0] duty1 = 4'h1;
  logic [W-1:0]  mask1 = 8'h00;
  logic [W-1:0]  led_out1;
  logic          frame_start1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_pwm_driver #(
    .WIDTH(W), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset(reset), .led_pattern(led_pattern), .duty(duty),
    .blink_mask(blink_mask), .led_out(led_out), .frame_start(frame_start)
  );

  led_pwm_driver #(
    .WIDTH(W), .PWM_BITS(PB), .PRESCALE(PS1), .BLINK_FRAMES(BF)
  ) dut1 (
    .clk(clk), .reset(reset), .led_pattern(pat1), .duty(duty1),
    .blink_mask(mask1), .led_out(led_out1), .frame_start(frame_start1)
  );

  // LED value driven in cycle c+1, given the inputs latched for the frame that
  // contains cycle c (cycles counted from the first cycle after reset).
  function automatic logic [W-1:0] model_led(input int unsigned c, input int unsigned p,
                                             input logic [W-1:0] pat, input logic [PB-1:0] d,
                                             input logic [W-1:0] m);
    int unsigned flen  = p * (1 << PB);
    int unsigned frame = c / flen;
    int unsigned level = (c % flen) / p;
    bit blink_dark     = ((frame / BF) % 2) == 1;
    bit bright         = (int'(d) == (1 << PB) - 1) || (level < int'(d));
    if (!bright) return '0;
    return blink_dark ? (pat & ~m) : pat;
  endfunction

  int unsigned   t0 = 0, t1 = 0;
  logic [W-1:0]  sp0 = '0, sm0 = '0, sp1 = '0, sm1 = '0;
  logic [PB-1:0] sd0 = '0, sd1 = '0;
  logic [W-1:0]  exp_led0 = '0, exp_led1 = '0;
  logic          exp_fs0 = 1'b0, exp_fs1 = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      t0 <= 0; sp0 <= '0; sd0 <= '0; sm0 <= '0; exp_led0 <= '0; exp_fs0 <= 1'b0;
      t1 <= 0; sp1 <= '0; sd1 <= '0; sm1 <= '0; exp_led1 <= '0; exp_fs1 <= 1'b0;
    end else begin
      exp_led0 <= model_led(t0, PS, sp0, sd0, sm0);
      exp_fs0  <= (t0 % F) == F - 1;
      if ((t0 % F) == F - 1) begin
        sp0 <= led_pattern; sd0 <= duty; sm0 <= blink_mask;
      end
      t0 <= t0 + 1;

      exp_led1 <= model_led(t1, PS1, sp1, sd1, sm1);
      exp_fs1  <= (t1 % F1) == F1 - 1;
      if ((t1 % F1) == F1 - 1) begin
        sp1 <= pat1; sd1 <= duty1; sm1 <= mask1;
      end
      t1 <= t1 + 1;
    end
  end

  task automatic expect_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    expect_eq("model_led",  led_out,                exp_led0);
    expect_eq("model_fs",   W'(frame_start),        W'(exp_fs0));
    expect_eq("model_led1", led_out1,               exp_led1);
    expect_eq("model_fs1",  W'(frame_start1),       W'(exp_fs1));
  endtask

  task automatic next_fs();
    int unsigned n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 2 * F);
    expect_eq("fs_reached", W'(frame_start), W'(1'b1));
  endtask

  task automatic measure_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                               output int na, output int nb);
    na = 0;
    nb = 0;
    repeat (F) begin
      step();
      if (led_out === a) na++;
      else if (led_out === b) nb++;
    end
  endtask

  task automatic check_restart(input logic [W-1:0] first_led);
    for (int i = 0; i < 32; i++) begin
      expect_eq("dark_after_reset", led_out, '0);
      expect_eq("no_fs_after_reset", W'(frame_start), '0);
      step();
    end
    expect_eq("first_fs", W'(frame_start), W'(1'b1));
    expect_eq("led_at_first_fs", led_out, '0);
    step();
    expect_eq("first_led", led_out, first_led);
  endtask

  initial begin
    int na, nb, n, nlit, ndark;
    bit lit[4];

    // Reset held three cycles with full pattern and duty pending.
    repeat (3) begin
      step();
      expect_eq("reset_led", led_out, '0);
      expect_eq("reset_fs", W'(frame_start), '0);
    end
    reset = 1'b0;
    check_restart(8'hFF);

    // Duty cycle: 4 of 16 levels, off, full.
    led_pattern = 8'h0F; duty = 4'd4;
    next_fs();
    measure_frame(8'h0F, 8'h00, na, nb);
    expect_eq("duty4_on", W'(na), W'(8));
    expect_eq("duty4_off", W'(nb), W'(24));
    duty = 4'd0;
    next_fs();
    measure_frame(8'h0F, 8'h00, na, nb);
    expect_eq("duty0_on", W'(na), W'(0));
    expect_eq("duty0_off", W'(nb), W'(32));
    duty = 4'hF;
    next_fs();
    measure_frame(8'h0F, 8'h00, na, nb);
    expect_eq("dutyF_on", W'(na), W'(32));

    // Frame sync: a mid-frame change waits for the next frame.
    repeat (5) step();
    led_pattern = 8'hF0;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * F) begin
      expect_eq("sync_hold", led_out, 8'h0F);
      step();
      n++;
    end
    expect_eq("sync_fs", W'(frame_start), W'(1'b1));
    expect_eq("sync_fs_led", led_out, 8'h0F);
    step();
    expect_eq("sync_new", led_out, 8'hF0);

    // A value present only in the frame_end cycle is captured.
    repeat (F - 2) step();
    led_pattern = 8'h3C;
    step();
    expect_eq("fe_fs", W'(frame_start), W'(1'b1));
    led_pattern = 8'hF0;
    step();
    expect_eq("fe_capture", led_out, 8'h3C);

    // Blink: LEDs 0 and 7 alternate two frames lit, two frames dark.
    led_pattern = 8'hFF; blink_mask = 8'h81; duty = 4'hF;
    next_fs();
    nlit = 0; ndark = 0;
    for (int i = 0; i < 4; i++) begin
      measure_frame(8'hFF, 8'h7E, na, nb);
      lit[i] = (na == int'(F));
      if (na == int'(F)) nlit++;
      if (nb == int'(F)) ndark++;
    end
    expect_eq("blink_lit_frames", W'(nlit), W'(2));
    expect_eq("blink_dark_frames", W'(ndark), W'(2));
    expect_eq("blink_period_a", W'(lit[0] ^ lit[2]), W'(1'b1));
    expect_eq("blink_period_b", W'(lit[1] ^ lit[3]), W'(1'b1));

    led_pattern = 8'h7E;
    next_fs();
    repeat (2 * F) begin
      step();
      expect_eq("blink_masked_off", led_out & 8'h81, 8'h00);
    end

    // Reset mid-frame, at level 9, in a dark blink phase.
    led_pattern = 8'hFF;
    next_fs();
    step();
    n = 0;
    while (led_out !== 8'h7E && n < 4) begin
      next_fs();
      step();
      n++;
    end
    expect_eq("found_dark_frame", led_out, 8'h7E);
    repeat (17) step();
    expect_eq("pre_reset_led", led_out, 8'h7E);
    reset = 1'b1;
    step();
    expect_eq("midreset_led", led_out, '0);
    expect_eq("midreset_fs", W'(frame_start), '0);
    reset = 1'b0;
    check_restart(8'hFF);

    // PRESCALE=1 instance: duty 1 lights exactly one cycle per 16-cycle frame.
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start1 !== 1'b1 && n < 2 * F1);
    expect_eq("fs1_reached", W'(frame_start1), W'(1'b1));
    na = 0;
    repeat (F1) begin
      step();
      if (led_out1 === 8'hFF) na++;
    end
    expect_eq("p1_duty1_on", W'(na), W'(1));

    // Randomized inputs, hold times and occasional resets.
    for (int k = 0; k < 24; k++) begin
      led_pattern = W'($urandom);
      duty        = PB'($urandom);
      blink_mask  = W'($urandom);
      pat1        = W'($urandom);
      duty1       = PB'($urandom);
      mask1       = W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      repeat ($urandom_range(1, 60)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
